// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-port register file with write-pending scoreboard
//
// Purpose: register file with two write ports (ALU and load writeback), optional
// same-cycle write-to-read bypass, optional hardwired zero register and
// per-register busy tracking so decode can spot RAW hazards locally.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   rs1, rs2                    read addresses
//   readData1/2, busy1/2        combinational read data and pending-write flags
//   RegWrite0, rd0, WriteData0  write port 0 (ALU writeback)
//   RegWrite1, rd1, WriteData1  write port 1 (load writeback, wins on collision)
//   Issue, rdIssue              mark a destination register as pending
//   pendingCount                number of busy registers (registered)
module register_file_sb #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [WIDTH-1:0]      readData1,
  output logic [WIDTH-1:0]      readData2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  RegWrite0,
  input  logic [ADDR_WIDTH-1:0] rd0,
  input  logic [WIDTH-1:0]      WriteData0,
  input  logic                  RegWrite1,
  input  logic [ADDR_WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0]      WriteData1,
  input  logic                  Issue,
  input  logic [ADDR_WIDTH-1:0] rdIssue,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]    regs [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_next;
  logic [ADDR_WIDTH:0] pend;
  logic [ADDR_WIDTH:0] pend_next;

  // Effective enables: anything aimed at a hardwired zero register is dropped.
  logic we0, we1, iss;
  assign we0 = RegWrite0 && !((ZERO_REG != 0) && (rd0 == '0));
  assign we1 = RegWrite1 && !((ZERO_REG != 0) && (rd1 == '0));
  assign iss = Issue && !((ZERO_REG != 0) && (rdIssue == '0));

  // Writebacks clear, then issue sets, so a same-cycle issue keeps the
  // register busy for the newer producer.
  always_comb begin
    busy_next = busy;
    if (we0) busy_next[rd0] = 1'b0;
    if (we1) busy_next[rd1] = 1'b0;
    if (iss) busy_next[rdIssue] = 1'b1;
  end

  // Incremental count: each real 0->1 or 1->0 transition moves it by one.
  // Port 1 does not count again when it hits the same register as port 0.
  logic inc, dec0, dec1;
  always_comb begin
    inc  = iss && !busy[rdIssue];
    dec0 = we0 && busy[rd0] && !(iss && (rdIssue == rd0));
    dec1 = we1 && busy[rd1] && !(iss && (rdIssue == rd1)) && !(we0 && (rd0 == rd1));
    pend_next = pend + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec0)
                     - (ADDR_WIDTH+1)'(dec1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      pend <= '0;
    end else begin
      if (we0) regs[rd0] <= WriteData0;
      if (we1) regs[rd1] <= WriteData1;  // later assignment gives port 1 priority
      busy <= busy_next;
      pend <= pend_next;
    end
  end

  function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_WIDTH-1:0] rs);
    if ((ZERO_REG != 0) && (rs == '0)) return '0;
    if ((BYPASS != 0) && we1 && (rd1 == rs)) return WriteData1;
    if ((BYPASS != 0) && we0 && (rd0 == rs)) return WriteData0;
    return regs[rs];
  endfunction

  // A bypassed register is reported not busy: its producer is completing now.
  function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] rs);
    if ((ZERO_REG != 0) && (rs == '0)) return 1'b0;
    if ((BYPASS != 0) && ((we1 && (rd1 == rs)) || (we0 && (rd0 == rs)))) return 1'b0;
    return busy[rs];
  endfunction

  assign readData1    = read_data(rs1);
  assign readData2    = read_data(rs2);
  assign busy1        = read_busy(rs1);
  assign busy2        = read_busy(rs2);
  assign pendingCount = pend;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - randomized and directed bench for register_file_sb
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd0, rd1, rdIssue;
  logic        RegWrite0, RegWrite1, Issue;
  logic [63:0] WriteData0, WriteData1;

  // Instance 0: ZERO_REG=1, BYPASS=1.  Instance 1: ZERO_REG=0, BYPASS=0.
  logic [63:0] o_rd1 [2];
  logic [63:0] o_rd2 [2];
  logic        o_b1  [2];
  logic        o_b2  [2];
  logic [5:0]  o_pc  [2];

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  register_file_sb #(.WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .readData1(o_rd1[0]), .readData2(o_rd2[0]), .busy1(o_b1[0]), .busy2(o_b2[0]),
    .RegWrite0(RegWrite0), .rd0(rd0), .WriteData0(WriteData0),
    .RegWrite1(RegWrite1), .rd1(rd1), .WriteData1(WriteData1),
    .Issue(Issue), .rdIssue(rdIssue), .pendingCount(o_pc[0]));

  register_file_sb #(.WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .readData1(o_rd1[1]), .readData2(o_rd2[1]), .busy1(o_b1[1]), .busy2(o_b2[1]),
    .RegWrite0(RegWrite0), .rd0(rd0), .WriteData0(WriteData0),
    .RegWrite1(RegWrite1), .rd1(rd1), .WriteData1(WriteData1),
    .Issue(Issue), .rdIssue(rdIssue), .pendingCount(o_pc[1]));

  // Reference model: architectural contents and pending flags per instance.
  logic [63:0] m_regs [2][32];
  bit          m_busy [2][32];

  function automatic bit zr(int k); return (k == 0); endfunction
  function automatic bit bp(int k); return (k == 0); endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] = '0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (RegWrite0 && !(zr(k) && rd0 == 0)) begin
          m_regs[k][rd0] = WriteData0;
          m_busy[k][rd0] = 1'b0;
        end
        if (RegWrite1 && !(zr(k) && rd1 == 0)) begin
          m_regs[k][rd1] = WriteData1;
          m_busy[k][rd1] = 1'b0;
        end
        if (Issue && !(zr(k) && rdIssue == 0)) m_busy[k][rdIssue] = 1'b1;
      end
    end
  end

  function automatic logic [63:0] exp_data(int k, logic [4:0] rs);
    if (zr(k) && rs == 0) return '0;
    if (bp(k) && RegWrite1 && rd1 == rs) return WriteData1;
    if (bp(k) && RegWrite0 && rd0 == rs) return WriteData0;
    return m_regs[k][rs];
  endfunction

  function automatic logic exp_busy(int k, logic [4:0] rs);
    if (zr(k) && rs == 0) return 1'b0;
    if (bp(k) && ((RegWrite1 && rd1 == rs) || (RegWrite0 && rd0 == rs))) return 1'b0;
    return m_busy[k][rs];
  endfunction

  function automatic logic [63:0] exp_count(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
    return 64'(c);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rd1[%0d]", k), o_rd1[k], exp_data(k, rs1));
        chk($sformatf("model_rd2[%0d]", k), o_rd2[k], exp_data(k, rs2));
        chk($sformatf("model_busy1[%0d]", k), 64'(o_b1[k]), 64'(exp_busy(k, rs1)));
        chk($sformatf("model_busy2[%0d]", k), 64'(o_b2[k]), 64'(exp_busy(k, rs2)));
        chk($sformatf("model_count[%0d]", k), 64'(o_pc[k]), exp_count(k));
      end
    end
  end

  task automatic idle();
    RegWrite0 = 0; rd0 = 0; WriteData0 = 0;
    RegWrite1 = 0; rd1 = 0; WriteData1 = 0;
    Issue = 0; rdIssue = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 0; rs1 = 0; rs2 = 0; idle();
    step(); step();

    // Reset overrides a same-cycle write and issue.
    RegWrite0 = 1; rd0 = 2; WriteData0 = 33; Issue = 1; rdIssue = 2; rs1 = 2;
    step(); reset = 1; idle(); cmp_en = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", o_rd1[k], 64'd0);
      chk("rst_busy", 64'(o_b1[k]), 64'd0);
      chk("rst_count", 64'(o_pc[k]), 64'd0);
    end

    // Basic write and disabled write.
    step(); RegWrite0 = 1; rd0 = 1; WriteData0 = 25; rs1 = 1;
    @(negedge clk);
    chk("bypass_same_cycle", o_rd1[0], 64'd25);
    chk("nobypass_before_edge", o_rd1[1], 64'd0);
    step(); idle(); rd0 = 3; WriteData0 = 44; rs2 = 3;
    @(negedge clk);
    chk("write_after_edge_a", o_rd1[0], 64'd25);
    chk("write_after_edge_b", o_rd1[1], 64'd25);
    step();
    @(negedge clk);
    chk("disabled_write", o_rd2[1], 64'd0);

    // Dual-port collision: port 1 wins.
    step(); RegWrite0 = 1; rd0 = 5; WriteData0 = 7; RegWrite1 = 1; rd1 = 5; WriteData1 = 9; rs1 = 5;
    @(negedge clk);
    chk("collision_bypass", o_rd1[0], 64'd9);
    step(); idle();
    @(negedge clk);
    chk("collision_a", o_rd1[0], 64'd9);
    chk("collision_b", o_rd1[1], 64'd9);

    // Zero register.
    step(); RegWrite0 = 1; rd0 = 0; WriteData0 = 64'hFF; Issue = 1; rdIssue = 0; rs1 = 0;
    step(); idle();
    @(negedge clk);
    chk("zero_data", o_rd1[0], 64'd0);
    chk("zero_busy", 64'(o_b1[0]), 64'd0);
    chk("zero_count", 64'(o_pc[0]), 64'd0);
    chk("nozero_data", o_rd1[1], 64'hFF);
    chk("nozero_busy", 64'(o_b1[1]), 64'd1);
    chk("nozero_count", 64'(o_pc[1]), 64'd1);
    step(); RegWrite0 = 1; rd0 = 0; WriteData0 = 64'hFF;
    step(); idle();
    @(negedge clk);
    chk("nozero_cleared", 64'(o_pc[1]), 64'd0);

    // Scoreboard.
    step(); Issue = 1; rdIssue = 4; rs1 = 4;
    step(); rdIssue = 6;
    @(negedge clk);
    chk("issue_count1", 64'(o_pc[0]), 64'd1);
    chk("issue_busy", 64'(o_b1[0]), 64'd1);
    step(); idle();
    @(negedge clk);
    chk("issue_count2", 64'(o_pc[0]), 64'd2);
    step(); RegWrite0 = 1; rd0 = 4; WriteData0 = 40; RegWrite1 = 1; rd1 = 6; WriteData1 = 60;
    @(negedge clk);
    chk("wb_bypass_busy", 64'(o_b1[0]), 64'd0);
    chk("wb_nobypass_busy", 64'(o_b1[1]), 64'd1);
    step(); idle();
    @(negedge clk);
    chk("wb_count_a", 64'(o_pc[0]), 64'd0);
    chk("wb_count_b", 64'(o_pc[1]), 64'd0);
    step(); Issue = 1; rdIssue = 4;
    step(); RegWrite0 = 1; rd0 = 4; WriteData0 = 41;
    step(); idle();
    @(negedge clk);
    chk("issue_wins_busy", 64'(o_b1[0]), 64'd1);
    chk("issue_wins_count", 64'(o_pc[0]), 64'd1);
    step(); RegWrite0 = 1; rd0 = 4; WriteData0 = 42;
    step(); idle();

    // Mid-operation reset.
    Issue = 1; rdIssue = 7; RegWrite0 = 1; rd0 = 7; WriteData0 = 70;
    step(); rdIssue = 8; rd0 = 8; WriteData0 = 80;
    step(); rdIssue = 9; rd0 = 9; WriteData0 = 90;
    step(); idle(); rs1 = 7;
    @(negedge clk);
    chk("pre_reset_data", o_rd1[0], 64'd70);
    chk("pre_reset_count", 64'(o_pc[0]), 64'd3);
    step(); reset = 0;
    step(); reset = 1;
    @(negedge clk);
    chk("mid_reset_data", o_rd1[0], 64'd0);
    chk("mid_reset_count", 64'(o_pc[0]), 64'd0);
    step(); Issue = 1; rdIssue = 10;
    step(); idle();
    @(negedge clk);
    chk("post_reset_count", 64'(o_pc[0]), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset      = ($urandom_range(0, 99) != 0);
      rs1        = rnd_addr();
      rs2        = rnd_addr();
      RegWrite0  = $urandom_range(0, 2) == 0;
      rd0        = rnd_addr();
      WriteData0 = {$urandom, $urandom};
      RegWrite1  = $urandom_range(0, 2) == 0;
      rd1        = ($urandom_range(0, 3) == 0) ? rd0 : rnd_addr();
      WriteData1 = {$urandom, $urandom};
      Issue      = $urandom_range(0, 1) == 1;
      rdIssue    = ($urandom_range(0, 3) == 0) ? rd0 : rnd_addr();
    end
    step(); reset = 1; idle();
    @(negedge clk);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
